// File: rtl/axi_master_arb.sv
// N-port AXI-lite to AXI4 master bridge with independent read and write arbitration.
// Define AXI_ARB_RR_EN for per-channel round-robin; otherwise fixed priority (lowest index wins).
module axi_master_arb #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_araddr_i,
    input  logic [NUM_PORTS-1:0]             req_arvalid_i,
    output logic [NUM_PORTS-1:0]             req_arready_o,
    output logic [DATA_WIDTH-1:0]            req_rdata_o,
    output logic [1:0]                       req_rresp_o,
    output logic [NUM_PORTS-1:0]             req_rvalid_o,
    input  logic [NUM_PORTS-1:0]             req_rready_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_awaddr_i,
    input  logic [NUM_PORTS-1:0]             req_awvalid_i,
    output logic [NUM_PORTS-1:0]             req_awready_o,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wstrb_i,
    input  logic [NUM_PORTS-1:0]             req_wvalid_i,
    output logic [NUM_PORTS-1:0]             req_wready_o,
    output logic [1:0]                       req_bresp_o,
    output logic [NUM_PORTS-1:0]             req_bvalid_o,
    input  logic [NUM_PORTS-1:0]             req_bready_i,
    output logic                             arvalid_o,
    input  logic                             arready_i,
    output logic [ID_WIDTH-1:0]              arid_o,
    output logic [ADDR_WIDTH-1:0]            araddr_o,
    output logic [7:0]                       arlen_o,
    output logic [2:0]                       arsize_o,
    output logic [1:0]                       arburst_o,
    input  logic                             rvalid_i,
    output logic                             rready_o,
    input  logic [ID_WIDTH-1:0]              rid_i,
    input  logic [DATA_WIDTH-1:0]            rdata_i,
    input  logic [1:0]                       rresp_i,
    input  logic                             rlast_i,
    output logic                             awvalid_o,
    input  logic                             awready_i,
    output logic [ID_WIDTH-1:0]              awid_o,
    output logic [ADDR_WIDTH-1:0]            awaddr_o,
    output logic [7:0]                       awlen_o,
    output logic [2:0]                       awsize_o,
    output logic [1:0]                       awburst_o,
    output logic                             wvalid_o,
    input  logic                             wready_i,
    output logic [DATA_WIDTH-1:0]            wdata_o,
    output logic [DATA_WIDTH/8-1:0]          wstrb_o,
    output logic                             wlast_o,
    input  logic                             bvalid_i,
    output logic                             bready_o,
    input  logic [ID_WIDTH-1:0]              bid_i,
    input  logic [1:0]                       bresp_i
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SIZE       = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} w_state_e;

    // Returns {found, index}: first requester at or after ptr, wrapping.
    function automatic logic [IDX_W:0] arb_pick(input logic [NUM_PORTS-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int idx;
        res = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (req[idx]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    r_state_e               r_state_q, r_state_d;
    w_state_e               w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]  r_addr_q, r_addr_d, w_addr_q, w_addr_d;
    logic [IDX_W-1:0]       r_gnt_q, r_gnt_d, w_gnt_q, w_gnt_d;
    logic [DATA_WIDTH-1:0]  w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0]  w_strb_q, w_strb_d;
    logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [IDX_W-1:0]       r_ptr, w_ptr;
    logic [IDX_W:0]         r_arb, w_arb;
    logic                   r_complete, w_complete;

    assign r_arb = arb_pick(req_arvalid_i, r_ptr);
    assign w_arb = arb_pick(req_awvalid_i & req_wvalid_i, w_ptr);

`ifdef AXI_ARB_RR_EN
    logic [IDX_W-1:0] r_ptr_q, r_ptr_d, w_ptr_q, w_ptr_d;

    always_comb begin
        r_ptr_d = r_ptr_q;
        w_ptr_d = w_ptr_q;
        if (r_complete) r_ptr_d = (r_gnt_q == IDX_W'(NUM_PORTS - 1)) ? '0 : r_gnt_q + 1'b1;
        if (w_complete) w_ptr_d = (w_gnt_q == IDX_W'(NUM_PORTS - 1)) ? '0 : w_gnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ptr_q <= '0;
            w_ptr_q <= '0;
        end else begin
            r_ptr_q <= r_ptr_d;
            w_ptr_q <= w_ptr_d;
        end
    end

    assign r_ptr = r_ptr_q;
    assign w_ptr = w_ptr_q;
`else
    assign r_ptr = '0;
    assign w_ptr = '0;
`endif

    assign arid_o    = ID_WIDTH'(r_gnt_q);
    assign araddr_o  = r_addr_q;
    assign arlen_o   = 8'd0;
    assign arsize_o  = 3'(SIZE);
    assign arburst_o = 2'b01;
    assign awid_o    = ID_WIDTH'(w_gnt_q);
    assign awaddr_o  = w_addr_q;
    assign awlen_o   = 8'd0;
    assign awsize_o  = 3'(SIZE);
    assign awburst_o = 2'b01;
    assign wdata_o   = w_data_q;
    assign wstrb_o   = w_strb_q;
    assign wlast_o   = 1'b1;

    always_comb begin
        r_state_d     = r_state_q;
        r_addr_d      = r_addr_q;
        r_gnt_d       = r_gnt_q;
        r_complete    = 1'b0;
        req_arready_o = '0;
        arvalid_o     = 1'b0;
        req_rvalid_o  = '0;
        rready_o      = 1'b0;
        req_rdata_o   = '0;
        req_rresp_o   = 2'b00;
        case (r_state_q)
            R_IDLE: begin
                if (r_arb[IDX_W]) begin
                    req_arready_o[r_arb[IDX_W-1:0]] = 1'b1;
                    r_addr_d  = req_araddr_i[r_arb[IDX_W-1:0]*ADDR_WIDTH +: ADDR_WIDTH];
                    r_gnt_d   = r_arb[IDX_W-1:0];
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                arvalid_o = 1'b1;
                if (arready_i) r_state_d = R_DATA;
            end
            R_DATA: begin
                req_rvalid_o[r_gnt_q] = rvalid_i;
                rready_o    = req_rready_i[r_gnt_q];
                req_rdata_o = rdata_i;
                // A foreign ID means the beat is not ours; report it as SLVERR.
                req_rresp_o = (rid_i != ID_WIDTH'(r_gnt_q)) ? 2'b10 : rresp_i;
                if (rvalid_i && req_rready_i[r_gnt_q] && rlast_i) begin
                    r_complete = 1'b1;
                    r_state_d  = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d     = w_state_q;
        w_addr_d      = w_addr_q;
        w_data_d      = w_data_q;
        w_strb_d      = w_strb_q;
        w_gnt_d       = w_gnt_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        w_complete    = 1'b0;
        req_awready_o = '0;
        req_wready_o  = '0;
        awvalid_o     = 1'b0;
        wvalid_o      = 1'b0;
        req_bvalid_o  = '0;
        bready_o      = 1'b0;
        req_bresp_o   = 2'b00;
        case (w_state_q)
            W_IDLE: begin
                if (w_arb[IDX_W]) begin
                    req_awready_o[w_arb[IDX_W-1:0]] = 1'b1;
                    req_wready_o[w_arb[IDX_W-1:0]]  = 1'b1;
                    w_addr_d  = req_awaddr_i[w_arb[IDX_W-1:0]*ADDR_WIDTH +: ADDR_WIDTH];
                    w_data_d  = req_wdata_i[w_arb[IDX_W-1:0]*DATA_WIDTH +: DATA_WIDTH];
                    w_strb_d  = req_wstrb_i[w_arb[IDX_W-1:0]*STRB_WIDTH +: STRB_WIDTH];
                    w_gnt_d   = w_arb[IDX_W-1:0];
                    w_state_d = W_REQ;
                end
            end
            W_REQ: begin
                // AW and W complete independently; each valid drops after its own handshake.
                awvalid_o = !aw_done_q;
                wvalid_o  = !w_done_q;
                aw_done_d = aw_done_q | awready_i;
                w_done_d  = w_done_q | wready_i;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                req_bvalid_o[w_gnt_q] = bvalid_i;
                bready_o    = req_bready_i[w_gnt_q];
                req_bresp_o = (bid_i != ID_WIDTH'(w_gnt_q)) ? 2'b10 : bresp_i;
                if (bvalid_i && req_bready_i[w_gnt_q]) begin
                    w_complete = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            r_addr_q  <= '0;
            r_gnt_q   <= '0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_gnt_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            r_addr_q  <= r_addr_d;
            r_gnt_q   <= r_gnt_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            w_gnt_q   <= w_gnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_master_arb.sv
// Self-checking bench for axi_master_arb: directed scenarios plus randomized concurrent
// read/write traffic against a transaction-level arbitration model.
module tb_axi_master_arb;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic clk, rst_n;
    logic [N*AW-1:0] req_araddr_i, req_awaddr_i;
    logic [N-1:0]    req_arvalid_i, req_arready_o, req_rvalid_o, req_rready_i;
    logic [DW-1:0]   req_rdata_o;
    logic [1:0]      req_rresp_o, req_bresp_o;
    logic [N-1:0]    req_awvalid_i, req_awready_o, req_wvalid_i, req_wready_o;
    logic [N*DW-1:0] req_wdata_i;
    logic [N*SW-1:0] req_wstrb_i;
    logic [N-1:0]    req_bvalid_o, req_bready_i;
    logic            arvalid_o, arready_i, rvalid_i, rready_o, rlast_i;
    logic [IW-1:0]   arid_o, rid_i, awid_o, bid_i;
    logic [AW-1:0]   araddr_o, awaddr_o;
    logic [7:0]      arlen_o, awlen_o;
    logic [2:0]      arsize_o, awsize_o;
    logic [1:0]      arburst_o, awburst_o, rresp_i, bresp_i;
    logic [DW-1:0]   rdata_i, wdata_o;
    logic            awvalid_o, awready_i, wvalid_o, wready_i, wlast_o;
    logic [SW-1:0]   wstrb_o;
    logic            bvalid_i, bready_o;

    axi_master_arb #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_araddr_i(req_araddr_i), .req_arvalid_i(req_arvalid_i), .req_arready_o(req_arready_o),
        .req_rdata_o(req_rdata_o), .req_rresp_o(req_rresp_o),
        .req_rvalid_o(req_rvalid_o), .req_rready_i(req_rready_i),
        .req_awaddr_i(req_awaddr_i), .req_awvalid_i(req_awvalid_i), .req_awready_o(req_awready_o),
        .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .req_wvalid_i(req_wvalid_i), .req_wready_o(req_wready_o),
        .req_bresp_o(req_bresp_o), .req_bvalid_o(req_bvalid_o), .req_bready_i(req_bready_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .arid_o(arid_o), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rid_i(rid_i), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awid_o(awid_o), .awaddr_o(awaddr_o),
        .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .wlast_o(wlast_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bid_i(bid_i), .bresp_i(bresp_i)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int rd_ptr   = 0;
    int wr_ptr   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Arbitration rule: round-robin from the channel pointer, or lowest index.
    function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
`ifdef AXI_ARB_RR_EN
        for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (mask[k]) return k;
`endif
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_read(input logic [N-1:0] mask, input logic [N*AW-1:0] addrs,
                           input logic [DW-1:0] data, input int rid_force, input logic [1:0] resp,
                           input int ar_dly, input int r_dly, output int g);
        logic [IW-1:0] rid;
        logic [1:0]    exp_resp;
        g        = model_pick(mask, rd_ptr);
        rid      = (rid_force >= 0) ? IW'(rid_force) : IW'(g);
        exp_resp = (rid != IW'(g)) ? 2'b10 : resp;
        @(negedge clk);
        req_araddr_i  = addrs;
        req_arvalid_i = mask;
        #1;
        check_eq("ar_accept", 64'(req_arready_o), 64'(1) << g);
        exp_q.push_back(data);
        @(negedge clk);
        req_arvalid_i = '0;
        for (int c = 0; c <= ar_dly; c++) begin
            arready_i = (c == ar_dly);
            #1;
            check_eq("arvalid_hold", 64'(arvalid_o), 64'(1));
            if (c == ar_dly) begin
                check_eq("arid", 64'(arid_o), 64'(g));
                check_eq("araddr", 64'(araddr_o), 64'(addrs[g*AW +: AW]));
                check_eq("ar_const", {arlen_o, arsize_o, arburst_o}, {8'd0, 3'd3, 2'b01});
            end
            @(negedge clk);
        end
        arready_i = 1'b0;
        for (int c = 0; c <= r_dly; c++) begin
            rvalid_i = (c == r_dly);
            rdata_i  = data;
            rid_i    = rid;
            rresp_i  = resp;
            rlast_i  = 1'b1;
            req_rready_i = '1;
            #1;
            check_eq("rvalid_route", 64'(req_rvalid_o), (c == r_dly) ? (64'(1) << g) : 64'(0));
            check_eq("rready", 64'(rready_o), 64'(1));
            if (c == r_dly) begin
                check_eq("rdata", req_rdata_o, exp_q.pop_front());
                check_eq("rresp", 64'(req_rresp_o), 64'(exp_resp));
            end
            @(negedge clk);
        end
        rvalid_i     = 1'b0;
        rlast_i      = 1'b0;
        req_rready_i = '0;
        rd_ptr       = (g + 1) % N;
        #1;
        check_eq("rd_back_idle", 64'(arvalid_o), 64'(0));
    endtask

    task automatic do_write(input logic [N-1:0] mask, input logic [N*AW-1:0] addrs,
                            input logic [N*DW-1:0] data, input logic [N*SW-1:0] strbs,
                            input int aw_dly, input int w_dly, input int bid_force,
                            input logic [1:0] resp, output int g);
        logic [IW-1:0] bid;
        int beats;
        int maxd;
        g     = model_pick(mask, wr_ptr);
        bid   = (bid_force >= 0) ? IW'(bid_force) : IW'(g);
        beats = 0;
        maxd  = (aw_dly > w_dly) ? aw_dly : w_dly;
        @(negedge clk);
        req_awaddr_i  = addrs;
        req_wdata_i   = data;
        req_wstrb_i   = strbs;
        req_awvalid_i = mask;
        req_wvalid_i  = mask;
        #1;
        check_eq("aw_accept", 64'(req_awready_o), 64'(1) << g);
        check_eq("w_accept", 64'(req_wready_o), 64'(1) << g);
        @(negedge clk);
        req_awvalid_i = '0;
        req_wvalid_i  = '0;
        for (int c = 0; c <= maxd; c++) begin
            awready_i = (c == aw_dly);
            wready_i  = (c == w_dly);
            #1;
            check_eq("awvalid", 64'(awvalid_o), 64'(c <= aw_dly));
            check_eq("wvalid", 64'(wvalid_o), 64'(c <= w_dly));
            if (c == aw_dly) begin
                check_eq("awid", 64'(awid_o), 64'(g));
                check_eq("awaddr", 64'(awaddr_o), 64'(addrs[g*AW +: AW]));
                check_eq("aw_const", {awlen_o, awsize_o, awburst_o}, {8'd0, 3'd3, 2'b01});
            end
            if (c == w_dly) begin
                check_eq("wdata", wdata_o, data[g*DW +: DW]);
                check_eq("wstrb", 64'(wstrb_o), 64'(strbs[g*SW +: SW]));
                check_eq("wlast", 64'(wlast_o), 64'(1));
            end
            if (wvalid_o && wready_i) beats++;
            @(negedge clk);
        end
        awready_i = 1'b0;
        wready_i  = 1'b0;
        check_eq("w_beats", 64'(beats), 64'(1));
        bvalid_i     = 1'b1;
        bid_i        = bid;
        bresp_i      = resp;
        req_bready_i = '1;
        #1;
        check_eq("bvalid_route", 64'(req_bvalid_o), 64'(1) << g);
        check_eq("bready", 64'(bready_o), 64'(1));
        check_eq("bresp", 64'(req_bresp_o), (bid != IW'(g)) ? 64'(2) : 64'(resp));
        @(negedge clk);
        bvalid_i     = 1'b0;
        req_bready_i = '0;
        wr_ptr       = (g + 1) % N;
    endtask

    task automatic check_all_idle(input string tag);
        check_eq({tag, "_ar"}, {req_arready_o, req_awready_o, req_wready_o, arvalid_o}, '0);
        check_eq({tag, "_aw"}, {awvalid_o, wvalid_o, rready_o, bready_o}, '0);
        check_eq({tag, "_rb"}, {req_rvalid_o, req_bvalid_o, req_rresp_o, req_bresp_o}, '0);
        check_eq({tag, "_rdata"}, req_rdata_o, '0);
    endtask

    // ---------------- stimulus ----------------
    logic [N*AW-1:0] a_vec;
    logic [N*DW-1:0] d_vec;
    logic [N*SW-1:0] s_vec;
    int g0, g1;
    int exp_seq[4];

    initial begin
        rst_n = 1'b0;
        req_araddr_i = '0; req_arvalid_i = '0; req_rready_i = '0;
        req_awaddr_i = '0; req_awvalid_i = '0; req_wdata_i = '0; req_wstrb_i = '0;
        req_wvalid_i = '0; req_bready_i = '0;
        arready_i = 0; rvalid_i = 0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 0;
        awready_i = 0; wready_i = 0; bvalid_i = 0; bid_i = '0; bresp_i = '0;
        #1;
        check_all_idle("reset");
        check_eq("const_wlast", 64'(wlast_o), 64'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // All ports hold AR requests: rotating grants with round-robin, port 0 otherwise.
`ifdef AXI_ARB_RR_EN
        exp_seq = '{0, 1, 2, 0};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            a_vec = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000} + 96'(i);
            do_read(3'b111, a_vec, 64'(i) + 64'hA5A5_0000_0000_0000, -1, 2'b00, 0, 0, g0);
            check_eq("grant_seq", 64'(g0), 64'(exp_seq[i]));
        end

        // Single read from port 1.
        a_vec = '0;
        a_vec[1*AW +: AW] = 32'h8000_0010;
        do_read(3'b010, a_vec, 64'hDEAD_BEEF_0000_0001, -1, 2'b00, 1, 1, g0);
        check_eq("single_rd_port", 64'(g0), 64'(1));

        // Port 2 write; W accepted two cycles before AW.
        d_vec = '0;
        d_vec[2*DW +: DW] = 64'h1122_3344_5566_7788;
        s_vec = '0;
        s_vec[2*SW +: SW] = 8'h0F;
        a_vec = '0;
        a_vec[2*AW +: AW] = 32'h4000_0040;
        do_write(3'b100, a_vec, d_vec, s_vec, 2, 0, -1, 2'b00, g0);
        check_eq("wr_port", 64'(g0), 64'(2));

        // Concurrent read from port 0 and write from port 1.
        a_vec = {32'h0, 32'h5000_0008, 32'h6000_0000};
        d_vec = {64'h0, 64'hCAFE_F00D_1234_5678, 64'h0};
        s_vec = {8'h00, 8'hFF, 8'h00};
        fork
            do_read(3'b001, a_vec, 64'h0BAD_CAFE_0000_0002, -1, 2'b01, 0, 0, g0);
            do_write(3'b010, a_vec, d_vec, s_vec, 0, 0, -1, 2'b00, g1);
        join

        // Returned ID mismatch becomes SLVERR.
        do_read(3'b001, a_vec, 64'h5555_6666_7777_8888, 5, 2'b00, 0, 0, g0);

        // Reset while in the data phase of a port-1 read.
        @(negedge clk);
        req_arvalid_i = 3'b010;
        @(negedge clk);
        req_arvalid_i = '0;
        arready_i = 1'b1;
        @(negedge clk);
        arready_i = 1'b0;
        rvalid_i = 1'b1;
        rid_i = 4'd1;
        req_rready_i = '1;
        #1;
        check_eq("pre_rst_rvalid", 64'(req_rvalid_o), 64'(3'b010));
        rst_n = 1'b0;
        #1;
        check_all_idle("mid_rst");
        @(negedge clk);
        rvalid_i = 1'b0;
        req_rready_i = '0;
        rst_n = 1'b1;
        rd_ptr = 0;
        wr_ptr = 0;
        a_vec = '0;
        a_vec[1*AW +: AW] = 32'h8000_0100;
        do_read(3'b010, a_vec, 64'h0123_4567_89AB_CDEF, -1, 2'b00, 0, 0, g0);
        check_eq("post_rst_port", 64'(g0), 64'(1));

        // Randomized concurrent traffic.
        for (int i = 0; i < 16; i++) begin
            logic [N-1:0] rmask, wmask;
            int rid_f, bid_f;
            logic [DW-1:0] rdat;
            logic [N*AW-1:0] ra_vec;
            rmask = N'($urandom_range(1, 7));
            wmask = N'($urandom_range(1, 7));
            for (int p = 0; p < N; p++) begin
                ra_vec[p*AW +: AW] = $urandom;
                a_vec[p*AW +: AW]  = $urandom;
                d_vec[p*DW +: DW]  = {$urandom, $urandom};
                s_vec[p*SW +: SW]  = SW'($urandom);
            end
            rdat  = {$urandom, $urandom};
            rid_f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            bid_f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            fork
                do_read(rmask, ra_vec, rdat, rid_f, 2'($urandom_range(0, 3)),
                        $urandom_range(0, 3), $urandom_range(0, 3), g0);
                do_write(wmask, a_vec, d_vec, s_vec, $urandom_range(0, 3), $urandom_range(0, 3),
                         bid_f, 2'($urandom_range(0, 3)), g1);
            join
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
